// File: rtl/pgas_wb_pkg.sv
// Shared constants, FSM state type and burst helpers for the PGAS Wishbone memory slave.
package pgas_wb_pkg;

   localparam int unsigned ADR_W  = 32;
   localparam int unsigned DAT_W  = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned WADR_W = ADR_W - 2;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   localparam logic [1:0] BTE_LINEAR = 2'b00;
   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_LEAD   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_e;

   // Word-address bits that advance on an incrementing beat; the rest are held.
   function automatic logic [WADR_W-1:0] wrap_mask(input logic [1:0] bte);
      logic [WADR_W-1:0] m;
      case (bte)
         BTE_LINEAR: m = '1;
         BTE_WRAP4:  m = WADR_W'(4'h3);
         BTE_WRAP8:  m = WADR_W'(4'h7);
         BTE_WRAP16: m = WADR_W'(4'hF);
         default:    m = '1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/pgas_wb_mem_slave_if.sv
// Wishbone B3 bus bundle between a memory tile master and the PGAS memory slave.
interface pgas_wb_mem_slave_if;
   import pgas_wb_pkg::*;

   logic [ADR_W-1:0] wb_adr_i;
   logic             wb_cyc_i;
   logic             wb_stb_i;
   logic             wb_we_i;
   logic [SEL_W-1:0] wb_sel_i;
   logic [DAT_W-1:0] wb_dat_i;
   logic [2:0]       wb_cti_i;
   logic [1:0]       wb_bte_i;
   logic             wb_ack_o;
   logic             wb_err_o;
   logic             wb_rty_o;
   logic [DAT_W-1:0] wb_dat_o;

   modport slave (
      input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
      output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
   );

   modport master (
      output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
      input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
   );

endinterface

// File: rtl/pgas_sram_bytewise.sv
// Single-port synchronous-read RAM, 32-bit words with four byte enables, write-first output.
module pgas_sram_bytewise #(
   parameter  int unsigned DEPTH = 8192,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;
   logic [31:0] merged_c;

   always_comb begin
      merged_c = mem_q[addr_i];
      for (int b = 0; b < 4; b++) begin
         if (be_i[b]) merged_c[8*b +: 8] = wdata_i[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Write-first: a write cycle returns the merged new word.
   always_ff @(posedge clk) begin
      if (rst)       rdata_q <= '0;
      else if (we_i) rdata_q <= merged_c;
      else           rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pgas_wb_mem_slave.sv
// Wishbone B3 registered-feedback memory slave for PGAS memory tiles.
// Define OPTIMSOC_PGAS_MEM_ERR_EN to terminate out-of-range beats with err instead of wrapping.
module pgas_wb_mem_slave
   import pgas_wb_pkg::*;
#(
   parameter int unsigned MEM_SIZE    = 32768,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                rst,
   pgas_wb_mem_slave_if.slave  wb
);

   localparam int unsigned DEPTH  = MEM_SIZE / 4;
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam logic [WADR_W-1:0] BASE_W = WADR_W'(BASE_ADDR >> 2);
   localparam logic        HAS_WAIT = (WAIT_STATES != 0);
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES - 32'd1);

   state_e            state_q;
   logic [3:0]        wait_cnt_q;
   logic [WADR_W-1:0] beat_adr_q;
   logic              ack_q;
   logic              err_q;

   logic              req_c;
   logic              burst_c;
   logic              wr_en_c;
   logic              oor_cur_c;
   logic              oor_next_c;
   logic [WADR_W-1:0] adr_w_c;
   logic [WADR_W-1:0] mask_c;
   logic [WADR_W-1:0] next_adr_c;
   logic [IDX_W-1:0]  ram_idx_c;
   logic [DAT_W-1:0]  ram_rdata;
   logic              unused_adr_lsb;

   assign req_c      = wb.wb_cyc_i & wb.wb_stb_i;
   assign adr_w_c    = wb.wb_adr_i[ADR_W-1:2] - BASE_W;
   assign burst_c    = (wb.wb_cti_i == CTI_CONST) || (wb.wb_cti_i == CTI_INCR);
   assign mask_c     = wrap_mask(wb.wb_bte_i);
   assign next_adr_c = (wb.wb_cti_i == CTI_CONST) ? beat_adr_q
                     : (beat_adr_q & ~mask_c) | ((beat_adr_q + WADR_W'(1)) & mask_c);
   assign wr_en_c    = ack_q & req_c & wb.wb_we_i & ~rst;
   assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

`ifdef OPTIMSOC_PGAS_MEM_ERR_EN
   localparam logic [WADR_W-1:0] DEPTH_W = WADR_W'(DEPTH);
   assign oor_cur_c  = (beat_adr_q >= DEPTH_W);
   assign oor_next_c = (next_adr_c >= DEPTH_W);
`else
   assign oor_cur_c  = 1'b0;
   assign oor_next_c = 1'b0;
`endif

   // Writes use the current beat; read-burst beats prefetch the next address alongside the ack.
   always_comb begin
      ram_idx_c = IDX_W'(beat_adr_q);
      if (!wr_en_c && (state_q == ST_ACTIVE) && burst_c) ram_idx_c = IDX_W'(next_adr_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         beat_adr_q <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_c) begin
                  beat_adr_q <= adr_w_c;
                  wait_cnt_q <= '0;
                  state_q    <= HAS_WAIT ? ST_WAIT : ST_LEAD;
               end
            end
            ST_WAIT: begin
               if (!req_c)                     state_q    <= ST_IDLE;
               else if (wait_cnt_q == WAIT_LAST) state_q  <= ST_LEAD;
               else                            wait_cnt_q <= wait_cnt_q + 4'd1;
            end
            ST_LEAD: begin
               if (!req_c) begin
                  state_q <= ST_IDLE;
               end else begin
                  ack_q   <= ~oor_cur_c;
                  err_q   <= oor_cur_c;
                  state_q <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // A termination is pending here; only an unbroken, error-free burst continues.
               if (req_c && burst_c && !err_q) begin
                  beat_adr_q <= next_adr_c;
                  ack_q      <= ~oor_next_c;
                  err_q      <= oor_next_c;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   pgas_sram_bytewise #(.DEPTH(DEPTH)) u_sram (
      .clk     (clk),
      .rst     (rst),
      .addr_i  (ram_idx_c),
      .we_i    (wr_en_c),
      .be_i    (wb.wb_sel_i),
      .wdata_i (wb.wb_dat_i),
      .rdata_o (ram_rdata)
   );

   assign wb.wb_ack_o = ack_q & req_c;
`ifdef OPTIMSOC_PGAS_MEM_ERR_EN
   assign wb.wb_err_o = err_q & req_c;
`else
   assign wb.wb_err_o = 1'b0;
`endif
   assign wb.wb_rty_o = 1'b0;
   assign wb.wb_dat_o = err_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_pgas_wb_mem_slave.sv
// Directed bench for pgas_wb_mem_slave (MEM_SIZE=4096, WAIT_STATES=2); honours OPTIMSOC_PGAS_MEM_ERR_EN.
module tb_pgas_wb_mem_slave;
   import pgas_wb_pkg::*;

   localparam int NV = 16;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdat;
      logic [31:0] exp_dat;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   pgas_wb_mem_slave_if wb ();

   pgas_wb_mem_slave #(
      .MEM_SIZE    (4096),
      .BASE_ADDR   (0),
      .WAIT_STATES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      wb.wb_cti_i = CTI_CLASSIC;
      wb.wb_bte_i = BTE_LINEAR;
      @(posedge clk); #1;
   endtask

   // One classic transfer; req is held one cycle past the termination to prove it does not repeat.
   task automatic classic(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat,
                          output logic is_err);
      logic done;
      done = 1'b0; lat = -1; rd = '0; is_err = 1'b0;
      wb.wb_adr_i = adr; wb.wb_we_i = we; wb.wb_sel_i = sel; wb.wb_dat_i = wd;
      wb.wb_cti_i = CTI_CLASSIC; wb.wb_bte_i = BTE_LINEAR;
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (wb.wb_ack_o || wb.wb_err_o) begin
            done = 1'b1; lat = c; rd = wb.wb_dat_o; is_err = wb.wb_err_o;
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("term_1cyc", {30'b0, wb.wb_ack_o, wb.wb_err_o}, 32'h0);
      @(posedge clk); #1;
      bus_idle();
   endtask

   vec_t        vt [NV];
   logic [31:0] rd;
   int          lat;
   logic        is_err;
   int          b;
   logic        done;
   logic [31:0] wexp [4];
   logic [31:0] wadr [4];

   initial begin
      vt[0]  = '{32'h10,  1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
      vt[1]  = '{32'h10,  1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0};
      vt[2]  = '{32'h20,  1'b1, 4'hF, 32'h11223344, 32'h0, 1'b0};
      vt[3]  = '{32'h20,  1'b1, 4'h3, 32'hAABBCCDD, 32'h0, 1'b0};
      vt[4]  = '{32'h20,  1'b0, 4'hF, 32'h0, 32'h1122CCDD, 1'b0};
      vt[5]  = '{32'h00,  1'b1, 4'hF, 32'hA0A0A0A0, 32'h0, 1'b0};
      vt[6]  = '{32'h04,  1'b1, 4'hF, 32'hB1B1B1B1, 32'h0, 1'b0};
      vt[7]  = '{32'h08,  1'b1, 4'hF, 32'hC2C2C2C2, 32'h0, 1'b0};
      vt[8]  = '{32'h0C,  1'b1, 4'hF, 32'hD3D3D3D3, 32'h0, 1'b0};
      vt[9]  = '{32'hFFC, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
      vt[10] = '{32'hFFC, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0};
      vt[11] = '{32'h84,  1'b1, 4'hF, 32'h84848484, 32'h0, 1'b0};
      vt[12] = '{32'h24,  1'b1, 4'hF, 32'h12345678, 32'h0, 1'b0};
      vt[13] = '{32'h24,  1'b1, 4'h9, 32'hFFEEDDCC, 32'h0, 1'b0};
      vt[14] = '{32'h24,  1'b0, 4'hF, 32'h0, 32'hFF3456CC, 1'b0};
`ifdef OPTIMSOC_PGAS_MEM_ERR_EN
      vt[15] = '{32'h1000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1};
`else
      vt[15] = '{32'h1000, 1'b0, 4'hF, 32'h0, 32'hA0A0A0A0, 1'b0};
`endif
      wexp = '{32'hD3D3D3D3, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
      wadr = '{32'h0C, 32'h00, 32'h04, 32'h08};

      rst = 1'b1;
      wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
      wb.wb_cti_i = CTI_CLASSIC; wb.wb_bte_i = BTE_LINEAR;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", {31'b0, wb.wb_ack_o}, 32'h0);
      chk("rst_err", {31'b0, wb.wb_err_o}, 32'h0);
      chk("rst_rty", {31'b0, wb.wb_rty_o}, 32'h0);
      chk("rst_dat", wb.wb_dat_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         classic(vt[i].adr, vt[i].we, vt[i].sel, vt[i].wdat, rd, lat, is_err);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'd4);
         chk($sformatf("v%0d_err", i), {31'b0, is_err}, {31'b0, vt[i].exp_err});
         if (!vt[i].we) chk($sformatf("v%0d_dat", i), rd, vt[i].exp_dat);
      end

      // Wrap4 incrementing read burst from 0x0C.
      wb.wb_adr_i = 32'h0C; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
      wb.wb_cti_i = CTI_INCR; wb.wb_bte_i = BTE_WRAP4;
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
      b = 0;
      for (int c = 0; c < 30 && b < 4; c++) begin
         @(negedge clk);
         if (wb.wb_ack_o) begin
            chk($sformatf("wrap_b%0d_dat", b), wb.wb_dat_o, wexp[b]);
            chk($sformatf("wrap_b%0d_cyc", b), 32'(c), 32'(4 + b));
            b++;
         end
         @(posedge clk); #1;
         if (b < 4) begin
            wb.wb_adr_i = wadr[b];
            if (b == 3) wb.wb_cti_i = CTI_END;
         end
      end
      chk("wrap_beats", 32'(b), 32'd4);
      @(negedge clk);
      chk("wrap_ack_after_end", {31'b0, wb.wb_ack_o}, 32'h0);
      @(posedge clk); #1;
      bus_idle();

      // Linear write burst from 0x00, strobe dropped after three beats.
      wb.wb_adr_i = 32'h00; wb.wb_we_i = 1'b1; wb.wb_sel_i = 4'hF; wb.wb_dat_i = 32'h50000000;
      wb.wb_cti_i = CTI_INCR; wb.wb_bte_i = BTE_LINEAR;
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
      b = 0;
      for (int c = 0; c < 30 && b < 3; c++) begin
         @(negedge clk);
         if (wb.wb_ack_o) begin
            chk($sformatf("lin_b%0d_cyc", b), 32'(c), 32'(4 + b));
            b++;
         end
         @(posedge clk); #1;
         wb.wb_dat_i = 32'h50000000 + 32'(b);
         wb.wb_adr_i = 32'(4 * b);
      end
      chk("lin_beats", 32'(b), 32'd3);
      wb.wb_stb_i = 1'b0;
      @(negedge clk);
      chk("lin_drop_noack", {31'b0, wb.wb_ack_o}, 32'h0);
      @(posedge clk); #1;
      wb.wb_adr_i = 32'h0C; wb.wb_we_i = 1'b0; wb.wb_cti_i = CTI_CLASSIC; wb.wb_stb_i = 1'b1;
      done = 1'b0; lat = -1; rd = '0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (wb.wb_ack_o) begin done = 1'b1; lat = c; rd = wb.wb_dat_o; end
         @(posedge clk); #1;
      end
      chk("restart_lat", 32'(lat), 32'd4);
      chk("restart_dat_unwritten", rd, 32'hD3D3D3D3);
      bus_idle();
      for (int i = 0; i < 3; i++) begin
         classic(32'(4 * i), 1'b0, 4'hF, 32'h0, rd, lat, is_err);
         chk($sformatf("lin_rd%0d", i), rd, 32'h50000000 + 32'(i));
      end

      // Reset asserted while the second beat of a write burst is being acked.
      wb.wb_adr_i = 32'h80; wb.wb_we_i = 1'b1; wb.wb_sel_i = 4'hF; wb.wb_dat_i = 32'h80808080;
      wb.wb_cti_i = CTI_INCR; wb.wb_bte_i = BTE_LINEAR;
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
      b = 0;
      for (int c = 0; c < 30 && b < 1; c++) begin
         @(negedge clk);
         if (wb.wb_ack_o) begin
            chk("rstb_b0_cyc", 32'(c), 32'd4);
            b++;
         end
         @(posedge clk); #1;
      end
      chk("rstb_first_beat", 32'(b), 32'd1);
      wb.wb_adr_i = 32'h84; wb.wb_dat_i = 32'h77777777; rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstb_ack_low", {31'b0, wb.wb_ack_o}, 32'h0);
      chk("rstb_dat_zero", wb.wb_dat_o, 32'h0);
      bus_idle();
      classic(32'h84, 1'b0, 4'hF, 32'h0, rd, lat, is_err);
      chk("rstb_b1_unchanged", rd, 32'h84848484);
      chk("rstb_idle_lat", 32'(lat), 32'd4);
      classic(32'h80, 1'b0, 4'hF, 32'h0, rd, lat, is_err);
      chk("rstb_b0_written", rd, 32'h80808080);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
